// File: rtl/vend_controller.sv
// vend_controller: credit accumulation, vend arbitration and paced change payout
module vend_controller #(
   parameter int PRICE      = 55,
   parameter int MAX_CREDIT = 95,
   parameter int CREDIT_W   = 7,
   parameter int CHANGE_GAP = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                dimeDetected,
   input  logic                nickelDetected,
   input  logic                quarterDetected,
   input  logic                selectItem,
   input  logic                cancel,
   output logic [CREDIT_W-1:0] credit,
   output logic                dispense,
   output logic                changeDime,
   output logic                changeNickel,
   output logic                rejectCoin,
   output logic                busy
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] VEND   = 2'd1;
   localparam logic [1:0] CHANGE = 2'd2;
   localparam int SW = CREDIT_W + 1;
   localparam int GW = CHANGE_GAP > 1 ? $clog2(CHANGE_GAP) : 1;
   localparam logic [SW-1:0] PRICE_V   = SW'(PRICE);
   localparam logic [SW-1:0] MAX_V     = SW'(MAX_CREDIT);
   localparam logic [SW-1:0] DIME_V    = SW'(10);
   localparam logic [SW-1:0] NICKEL_V  = SW'(5);
   localparam logic [SW-1:0] QUARTER_V = SW'(25);
   localparam logic [GW-1:0] GAP_RELOAD = GW'(CHANGE_GAP - 1);

   logic [1:0]          state, stateNext;
   logic [GW-1:0]       gapCnt, gapNext;
   logic [CREDIT_W-1:0] creditNext, payRest;
   logic [SW-1:0]       creditX, coinValue, coinSum, idleCredit, payBase;
   logic [1:0]          coinCount;
   logic                coinFits, payDime, payNickel;
   logic                dispenseNext, dimeNext, nickelNext, rejectNext;

   // A coin is valued only when exactly one detector fires; simultaneous pulses are rejected.
   assign coinCount  = {1'b0, dimeDetected} + {1'b0, nickelDetected} + {1'b0, quarterDetected};
   assign coinValue  = coinCount != 2'd1 ? '0 : quarterDetected ? QUARTER_V : dimeDetected ? DIME_V : NICKEL_V;
   assign creditX    = {1'b0, credit};
   assign coinSum    = creditX + coinValue;
   assign coinFits   = coinValue != '0 && coinSum <= MAX_V;
   assign idleCredit = coinFits ? coinSum : creditX;
   // Change is paid from the coin-adjusted credit when leaving IDLE, otherwise from the register.
   assign payBase    = state == IDLE ? idleCredit : creditX;
   assign payDime    = payBase >= DIME_V;
   assign payNickel  = !payDime && payBase >= NICKEL_V;
   assign payRest    = CREDIT_W'(payBase - (payDime ? DIME_V : payNickel ? NICKEL_V : '0));
   assign busy       = state != IDLE;

   // Next-state, credit and output-pulse decisions for the coming edge.
   always_comb begin
      stateNext    = state;
      creditNext   = credit;
      gapNext      = gapCnt;
      dispenseNext = 1'b0;
      dimeNext     = 1'b0;
      nickelNext   = 1'b0;
      rejectNext   = coinCount != 2'd0 && (state != IDLE || !coinFits);
      case (state)
         IDLE: begin
            creditNext = idleCredit[CREDIT_W-1:0];
            if (cancel && credit != '0) begin
               stateNext  = CHANGE;
               creditNext = payRest;
               dimeNext   = payDime;
               nickelNext = payNickel;
               gapNext    = GAP_RELOAD;
            end else if (!cancel && selectItem && creditX >= PRICE_V) begin
               stateNext    = VEND;
               creditNext   = CREDIT_W'(idleCredit - PRICE_V);
               dispenseNext = 1'b1;
            end
         end
         VEND: begin
            stateNext = credit != '0 ? CHANGE : IDLE;
            if (credit != '0) begin
               creditNext = payRest;
               dimeNext   = payDime;
               nickelNext = payNickel;
               gapNext    = GAP_RELOAD;
            end
         end
         CHANGE: begin
            if (credit == '0) begin
               stateNext = IDLE;
            end else if (gapCnt == '0) begin
               creditNext = payRest;
               dimeNext   = payDime;
               nickelNext = payNickel;
               gapNext    = GAP_RELOAD;
            end else begin
               gapNext = gapCnt - 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Register state, credit, pacing counter and all pulse outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         credit       <= '0;
         gapCnt       <= '0;
         dispense     <= 1'b0;
         changeDime   <= 1'b0;
         changeNickel <= 1'b0;
         rejectCoin   <= 1'b0;
      end else begin
         state        <= stateNext;
         credit       <= creditNext;
         gapCnt       <= gapNext;
         dispense     <= dispenseNext;
         changeDime   <= dimeNext;
         changeNickel <= nickelNext;
         rejectCoin   <= rejectNext;
      end
   end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed and random stimulus against a payout-schedule reference model
module tb_vend_controller;
   localparam int PRICE = 55;
   localparam int MAXC  = 95;
   localparam int CW    = 7;
   localparam int GAP   = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dimeDetected = 1'b0, nickelDetected = 1'b0, quarterDetected = 1'b0;
   logic selectItem = 1'b0, cancel = 1'b0;
   logic [CW-1:0] credit;
   logic dispense, changeDime, changeNickel, rejectCoin, busy;

   int nChecks = 0;
   int nErrs = 0;
   int cyc = 0;
   int idleCredit = 0;
   int vendCyc = -10;
   int vendRem = 0;
   int payStart = -100;
   int payAmt = 0;
   int payDimes = 0;
   int payN = 0;
   bit expReject = 1'b0;

   vend_controller #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .CREDIT_W(CW), .CHANGE_GAP(GAP)) dut (
      .clk(clk), .reset(reset),
      .dimeDetected(dimeDetected), .nickelDetected(nickelDetected), .quarterDetected(quarterDetected),
      .selectItem(selectItem), .cancel(cancel),
      .credit(credit), .dispense(dispense), .changeDime(changeDime), .changeNickel(changeNickel),
      .rejectCoin(rejectCoin), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input int got, input int exp);
      nChecks++;
      if (got != exp) begin
         nErrs++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
      end
   endtask

   function automatic bit inPay(input int c);
      return payN > 0 && c >= payStart && c <= payStart + (payN - 1) * GAP;
   endfunction

   function automatic int paidBy(input int c);
      int done;
      done = (c - payStart) / GAP + 1;
      if (done > payN) done = payN;
      return done <= payDimes ? 10 * done : 10 * payDimes + 5 * (done - payDimes);
   endfunction

   function automatic void startPay(input int at, input int amt);
      payStart = at;
      payAmt   = amt;
      payDimes = amt / 10;
      payN     = payDimes + (amt % 10) / 5;
   endfunction

   task automatic step(input bit d, input bit n, input bit q, input bit sel, input bit can, input bit rst);
      int coins, value, total, j;
      bit fits, prevBusy, pulse, expDime;
      dimeDetected = d; nickelDetected = n; quarterDetected = q;
      selectItem = sel; cancel = can; reset = rst;
      @(posedge clk);
      cyc++;
      if (rst) begin
         idleCredit = 0; vendCyc = -10; payN = 0; payStart = -100; expReject = 1'b0;
      end else begin
         prevBusy = (cyc - 1 == vendCyc) || inPay(cyc - 1);
         coins = int'(d) + int'(n) + int'(q);
         value = coins != 1 ? 0 : q ? 25 : d ? 10 : 5;
         fits = coins == 1 && idleCredit + value <= MAXC;
         expReject = coins > 1 || (coins == 1 && (prevBusy || !fits));
         if (!prevBusy) begin
            total = idleCredit + (fits ? value : 0);
            if (can && idleCredit > 0) begin
               startPay(cyc, total);
               idleCredit = 0;
            end else if (sel && idleCredit >= PRICE) begin
               vendCyc = cyc;
               vendRem = total - PRICE;
               if (vendRem > 0) startPay(cyc + 1, vendRem);
               idleCredit = 0;
            end else begin
               idleCredit = total;
            end
         end
      end
      #1;
      j = cyc - payStart;
      pulse = inPay(cyc) && j % GAP == 0;
      expDime = pulse && j / GAP < payDimes;
      checkVal("credit", int'(credit), cyc == vendCyc ? vendRem : inPay(cyc) ? payAmt - paidBy(cyc) : idleCredit);
      checkVal("dispense", int'(dispense), int'(cyc == vendCyc));
      checkVal("changeDime", int'(changeDime), int'(expDime));
      checkVal("changeNickel", int'(changeNickel), int'(pulse && !expDime));
      checkVal("rejectCoin", int'(rejectCoin), int'(expReject));
      checkVal("busy", int'(busy), int'(cyc == vendCyc || inPay(cyc)));
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      // 60 cents then select: dispense plus one nickel
      step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0); idle(4);
      // 30 cents: select ignored, cancel pays three dimes
      step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 1, 0); idle(7);
      // Fill to 90, overflow quarter rejected, nickel reaches the 95 ceiling
      step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0); step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0); idle(22);
      // 60 cents with select and cancel together: cancel wins, six dimes
      step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0); idle(13);
      // Double coin rejected; coins during payout rejected without disturbing it
      step(1, 1, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0); step(1, 0, 0, 0, 0, 0); step(0, 0, 1, 1, 1, 0); idle(6);
      // Reset during payout of 40 cents
      step(0, 0, 1, 0, 0, 0); step(1, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 1); idle(6);
      // Exact price with a same-cycle coin added to the remainder
      for (int i = 0; i < 11; i++) step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0); idle(8);
      for (int i = 0; i < 1500; i++) begin
         int r, c;
         r = $urandom_range(0, 99);
         c = $urandom_range(0, 2);
         step(r < 35 ? (c == 0) || (r >= 32) : 1'b0,
              r < 35 ? (c == 1) || (r >= 32 && c != 0) : 1'b0,
              r < 35 ? (c == 2) : 1'b0,
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4, $urandom_range(0, 199) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrs);
      $finish;
   end
endmodule
